// File: rtl/as_sequencer_if.sv
// ---------------------------------------------------------------------------
// as_sequencer_if
//   Bundles the program-memory port and the ALU/register-file control bus
//   driven by as_sequencer.
//
//   Program memory: the sequencer presents pc and the memory returns the
//   addressed word on instr one cycle later. There is no valid/ready pair:
//   the memory is fixed-latency and always ready, so the sequencer simply
//   spends one FETCH cycle per instruction while the read is in flight.
//
//   Signals (sequencer view):
//     instr      in   16    program memory read data
//     z          in   1     ALU zero flag (combinational from current controls)
//     pc         out  PC_W  program memory address
//     rd_addr    out  3     register-file Rd index
//     rs_addr    out  3     register-file Rs index
//     immediate  out  n     ALU immediate operand
//     add_a_sel  out  1     adder A select (1 = SW[8] replicated)
//     add_b_sel  out  1     adder B select (1 = immediate, 0 = Rs*imm)
//     acc_en     out  1     ACC write enable
//     acc_add    out  1     feed ACC back into adder A
//     in_en      out  1     route SW[7:0] onto the writeback bus
//     reg_we     out  1     register-file write enable
//     halted     out  1     processor halted
//     illegal    out  1     one-cycle pulse on an undefined opcode
//
//   Modports: master = sequencer, slave = memory/datapath side.
// ---------------------------------------------------------------------------
interface as_sequencer_if #(
  parameter int n    = 8,
  parameter int PC_W = 8
);
  logic [15:0]   instr;
  logic          z;
  logic [PC_W-1:0] pc;
  logic [2:0]    rd_addr;
  logic [2:0]    rs_addr;
  logic [n-1:0]  immediate;
  logic          add_a_sel;
  logic          add_b_sel;
  logic          acc_en;
  logic          acc_add;
  logic          in_en;
  logic          reg_we;
  logic          halted;
  logic          illegal;

  modport master (
    input  instr, z,
    output pc, rd_addr, rs_addr, immediate,
    output add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we,
    output halted, illegal
  );

  modport slave (
    output instr, z,
    input  pc, rd_addr, rs_addr, immediate,
    input  add_a_sel, add_b_sel, acc_en, acc_add, in_en, reg_we,
    input  halted, illegal
  );
endinterface

// File: rtl/as_sequencer.sv
// ---------------------------------------------------------------------------
// as_sequencer
//   Instruction sequencer / control unit for the 8-bit ALU + register-file
//   datapath. Fetches 16-bit words from a synchronous-read program memory,
//   decodes them into datapath controls, and handles BRZ/BSW branches on the
//   ALU zero flag, a hardware REPEAT loop and HALT.
//
//   Ports:
//     clk        in   1   system clock, rising edge
//     n_reset    in   1   asynchronous active-low reset
//     step       in   1   single-step pushbutton (only with AS_SINGLE_STEP_EN)
//     bus        as_sequencer_if.master (program memory + datapath controls)
//     dbg_state  out  2   current FSM state (0 FETCH, 1 EXEC, 2 HALT)
//
//   Optional feature macro: AS_SINGLE_STEP_EN
//     Defined   : a synchronised rising edge on step is needed to leave
//                 FETCH, so one instruction (a whole REPEAT body counts as
//                 one) executes per press.
//     Undefined : no step port; FETCH always lasts exactly one cycle.
//
//   Instruction fields: op=[15:12] rd=[11:9] rs=[8:6] imm=[7:0]
//   (imm overlaps rs; immediate-only ops simply ignore rs).
// ---------------------------------------------------------------------------
module as_sequencer #(
  parameter int n    = 8,
  parameter int PC_W = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
`ifdef AS_SINGLE_STEP_EN
  input  logic                 step,
`endif
  as_sequencer_if.master       bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ADDI   = 4'h1;
  localparam logic [3:0] OP_MACI   = 4'h2;
  localparam logic [3:0] OP_IN     = 4'h3;
  localparam logic [3:0] OP_ACCI   = 4'h4;
  localparam logic [3:0] OP_BRZ    = 4'h5;
  localparam logic [3:0] OP_BSW    = 4'h6;
  localparam logic [3:0] OP_REPEAT = 4'h7;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      rpt_q, rpt_d;
  logic [15:0]     ir_q;
  logic            rep_q, rep_d;     // 1 while re-executing a held IR
  logic            fetch_go;

  // -------------------------------------------------------------------------
  // Instruction register
  //   The memory word addressed in FETCH arrives on instr during the first
  //   EXEC cycle, so that cycle decodes straight from instr and captures it.
  //   Repeat cycles decode from the captured copy, which keeps IR stable
  //   regardless of what the memory port does meanwhile.
  // -------------------------------------------------------------------------
  logic [15:0] ir_cur;
  logic [3:0]  op;
  logic [2:0]  f_rd;
  logic [2:0]  f_rs;
  logic [7:0]  f_imm;

  assign ir_cur = rep_q ? ir_q : bus.instr;
  assign op     = ir_cur[15:12];
  assign f_rd   = ir_cur[11:9];
  assign f_rs   = ir_cur[8:6];
  assign f_imm  = ir_cur[7:0];

  // -------------------------------------------------------------------------
  // Single-step front end
  // -------------------------------------------------------------------------
`ifdef AS_SINGLE_STEP_EN
  logic step_s1, step_s2, step_s3;
  logic step_rise;
  logic step_pend_q, step_pend_d;

  assign step_rise = step_s2 & ~step_s3;

  // A press seen outside FETCH is remembered so it is not lost; FETCH
  // consumes one pending press.
  always_comb begin
    step_pend_d = step_pend_q;
    if (state_q == S_FETCH && step_pend_q) begin
      step_pend_d = 1'b0;
    end
    if (step_rise) begin
      step_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      step_s1     <= 1'b0;
      step_s2     <= 1'b0;
      step_s3     <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_s1     <= step;
      step_s2     <= step_s1;
      step_s3     <= step_s2;
      step_pend_q <= step_pend_d;
    end
  end

  assign fetch_go = step_pend_q;
`else
  assign fetch_go = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      rpt_q   <= '0;
      ir_q    <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpt_q   <= rpt_d;
      rep_q   <= rep_d;
      if (state_q == S_EXEC) begin
        ir_q <= ir_cur;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next state, pc and repeat counter
  // -------------------------------------------------------------------------
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;

  assign pc_inc    = pc_q + PC_W'(1);   // wraps modulo 2**PC_W
  assign br_target = PC_W'(f_imm);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rpt_d   = rpt_q;
    unique case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_HALT: begin
            // pc stays on the HALT word; only reset leaves S_HALT.
            state_d = S_HALT;
            rpt_d   = '0;
          end
          OP_BRZ, OP_BSW: begin
            pc_d    = bus.z ? br_target : pc_inc;
            rpt_d   = '0;
            state_d = S_FETCH;
          end
          OP_REPEAT: begin
            rpt_d   = f_imm;
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
          default: begin
            // A count of 0 or 1 both mean a single execution.
            if (rpt_q > 8'd1) begin
              rpt_d = rpt_q - 8'd1;
            end else begin
              rpt_d   = '0;
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign rep_d = (state_q == S_EXEC) && (state_d == S_EXEC);

  // -------------------------------------------------------------------------
  // Control decode (only EXEC asserts anything; halted also covers the EXEC
  // cycle of the HALT word so it rises as soon as HALT is decoded)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.rd_addr   = '0;
    bus.rs_addr   = '0;
    bus.immediate = '0;
    bus.add_a_sel = 1'b0;
    bus.add_b_sel = 1'b0;
    bus.acc_en    = 1'b0;
    bus.acc_add   = 1'b0;
    bus.in_en     = 1'b0;
    bus.reg_we    = 1'b0;
    bus.halted    = (state_q == S_HALT);
    bus.illegal   = 1'b0;
    if (state_q == S_EXEC) begin
      bus.rd_addr   = f_rd;
      bus.rs_addr   = f_rs;
      bus.immediate = n'(f_imm);
      case (op)
        OP_NOP: begin
        end
        OP_ADDI: begin
          bus.add_b_sel = 1'b1;
          bus.reg_we    = 1'b1;
          bus.acc_en    = 1'b1;
        end
        OP_MACI: begin
          bus.reg_we = 1'b1;
          bus.acc_en = 1'b1;
        end
        OP_IN: begin
          bus.in_en  = 1'b1;
          bus.reg_we = 1'b1;
        end
        OP_ACCI: begin
          bus.acc_add   = 1'b1;
          bus.add_b_sel = 1'b1;
          bus.acc_en    = 1'b1;
        end
        OP_BRZ: begin
          // Rd + 0 through the adder: z reports whether Rd is zero.
          bus.add_b_sel = 1'b1;
          bus.immediate = '0;
        end
        OP_BSW: begin
          // SW[8] replicated + 0: z is high exactly when SW[8] is 0.
          bus.add_a_sel = 1'b1;
          bus.add_b_sel = 1'b1;
          bus.immediate = '0;
        end
        OP_REPEAT: begin
        end
        OP_HALT: begin
          bus.halted = 1'b1;
        end
        default: begin
          bus.illegal = 1'b1;
        end
      endcase
    end
  end

  assign bus.pc    = pc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_as_sequencer.sv
// ---------------------------------------------------------------------------
// tb_as_sequencer
//   Loads small programs into a synchronous-read memory model, pushes the
//   expected per-cycle output vector for each program into exp_q, then pops
//   and compares one entry per clock at the falling edge.
//   Vector layout: {pc, rd_addr, rs_addr, immediate,
//                   add_a, add_b, acc_en, acc_add, in_en, reg_we, halted, illegal}
// ---------------------------------------------------------------------------
module tb_as_sequencer;
  localparam int N    = 8;
  localparam int PC_W = 8;
  localparam int W    = 30;

  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_ADDI = 8'h64;
  localparam logic [7:0] C_MACI = 8'h24;
  localparam logic [7:0] C_IN   = 8'h0C;
  localparam logic [7:0] C_ACCI = 8'h70;
  localparam logic [7:0] C_BRZ  = 8'h40;
  localparam logic [7:0] C_BSW  = 8'hC0;
  localparam logic [7:0] C_HALT = 8'h02;
  localparam logic [7:0] C_ILL  = 8'h01;

  // clock / reset
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  as_sequencer_if #(.n(N), .PC_W(PC_W)) bus ();
  logic [1:0] dbg_state;
`ifdef AS_SINGLE_STEP_EN
  logic step = 1'b0;
`endif

  as_sequencer #(.n(N), .PC_W(PC_W)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
`ifdef AS_SINGLE_STEP_EN
    .step      (step),
`endif
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // program memory model and zero flag
  logic [15:0] mem [256];
  logic        z_drv = 1'b0;
  assign bus.z = z_drv;
  always @(posedge clk) bus.instr <= mem[bus.pc];

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sample();
    return {bus.pc, bus.rd_addr, bus.rs_addr, bus.immediate,
            bus.add_a_sel, bus.add_b_sel, bus.acc_en, bus.acc_add,
            bus.in_en, bus.reg_we, bus.halted, bus.illegal};
  endfunction

  // driver tasks
  task automatic push(input logic [7:0] pc, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [7:0] imm, input logic [7:0] ctl);
    exp_q.push_back({pc, rd, rs, imm, ctl});
  endtask

  task automatic push_halt(input logic [7:0] pc, input int k);
    for (int i = 0; i < k; i++) push(pc, 3'd0, 3'd0, 8'd0, C_HALT);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset(input string tag);
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_reset"}, sample(), '0);
    n_reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      i++;
      check($sformatf("%s_c%0d", tag, i), sample(), exp_q.pop_front());
    end
  endtask

  initial begin
    logic [2:0] r_rd;
    logic [7:0] r_imm;
    logic [7:0] r_pc;

    // ADDI r1,5 ; HALT
    clear_mem();
    mem[0] = 16'h1205;
    mem[1] = 16'hF000;
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd1, 3'd0, 8'h05, C_ADDI);
    push(8'h01, 3'd0, 3'd0, 8'h00, C_NONE);
    push_halt(8'h01, 21);
    do_reset("addi");
    drain("addi");

    // BRZ r2,0x10 taken / not taken
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      mem[0] = 16'h5410;
      z_drv = (t == 0);
      r_pc = z_drv ? 8'h10 : 8'h01;
      push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
      push(8'h00, 3'd2, 3'd0, 8'h00, C_BRZ);
      push(r_pc, 3'd0, 3'd0, 8'h00, C_NONE);
      push_halt(r_pc, 2);
      do_reset("brz");
      drain($sformatf("brz_z%0d", z_drv));
    end

    // BSW r6,0x20 with z=1
    clear_mem();
    mem[0] = 16'h6C20;
    z_drv = 1'b1;
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd6, 3'd0, 8'h00, C_BSW);
    push(8'h20, 3'd0, 3'd0, 8'h00, C_NONE);
    push_halt(8'h20, 2);
    do_reset("bsw");
    drain("bsw");
    z_drv = 1'b0;

    // REPEAT 3 ; MACI r1,r2 (imm field 0x82 overlaps rs) ; HALT
    clear_mem();
    mem[0] = 16'h7003;
    mem[1] = 16'h2282;
    push(8'h00, 3'd0, 3'd0, 8'h03, C_NONE);
    push(8'h00, 3'd0, 3'd0, 8'h03, C_NONE);
    exp_q.delete(0);
    push(8'h01, 3'd0, 3'd0, 8'h00, C_NONE);
    for (int i = 0; i < 3; i++) push(8'h01, 3'd1, 3'd2, 8'h82, C_MACI);
    push(8'h02, 3'd0, 3'd0, 8'h00, C_NONE);
    push_halt(8'h02, 2);
    exp_q.push_front({8'h00, 3'd0, 3'd0, 8'h00, C_NONE});
    do_reset("rpt3");
    drain("rpt3");

    // REPEAT 0 -> single execution
    mem[0] = 16'h7000;
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h01, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h01, 3'd1, 3'd2, 8'h82, C_MACI);
    push(8'h02, 3'd0, 3'd0, 8'h00, C_NONE);
    push_halt(8'h02, 2);
    do_reset("rpt0");
    drain("rpt0");

    // pc wrap: BRZ to 0xFF, NOP at 0xFF, wraps to 0
    clear_mem();
    mem[0]     = 16'h50FF;
    mem[8'hFF] = 16'h0000;
    z_drv = 1'b1;
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd0, 3'd3, 8'h00, C_BRZ);
    push(8'hFF, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'hFF, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    do_reset("wrap");
    drain("wrap");
    z_drv = 1'b0;

    // illegal opcode 0x9, then IN r3, ACCI 0x7F, HALT
    clear_mem();
    mem[0] = 16'h9000;
    mem[1] = 16'h3600;
    mem[2] = 16'h407F;
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd0, 3'd0, 8'h00, C_ILL);
    push(8'h01, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h01, 3'd3, 3'd0, 8'h00, C_IN);
    push(8'h02, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h02, 3'd0, 3'd1, 8'h7F, C_ACCI);
    push(8'h03, 3'd0, 3'd0, 8'h00, C_NONE);
    push_halt(8'h03, 2);
    do_reset("ill");
    drain("ill");

    // reset during the second cycle of a REPEAT 5 body
    clear_mem();
    mem[0] = 16'h7005;
    mem[1] = 16'h1205;
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd0, 3'd0, 8'h05, C_NONE);
    push(8'h01, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h01, 3'd1, 3'd0, 8'h05, C_ADDI);
    push(8'h01, 3'd1, 3'd0, 8'h05, C_ADDI);
    do_reset("abort");
    drain("abort");
    n_reset = 1'b0;
    #1;
    check("abort_async", sample(), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold%0d", i), sample(), '0);
    end
    @(posedge clk);
    #1 n_reset = 1'b1;
    push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h00, 3'd0, 3'd0, 8'h05, C_NONE);
    push(8'h01, 3'd0, 3'd0, 8'h00, C_NONE);
    push(8'h01, 3'd1, 3'd0, 8'h05, C_ADDI);
    drain("rerun");

    // random ADDI fields and random branch direction
    for (int k = 0; k < 6; k++) begin
      clear_mem();
      r_rd  = 3'($urandom_range(0, 7));
      r_imm = 8'($urandom_range(0, 255));
      z_drv = 1'($urandom_range(0, 1));
      mem[0] = {4'h1, r_rd, 1'b0, r_imm};
      mem[1] = {4'h5, r_rd, 1'b0, 8'h40};
      r_pc = z_drv ? 8'h40 : 8'h02;
      push(8'h00, 3'd0, 3'd0, 8'h00, C_NONE);
      push(8'h00, r_rd, {1'b0, r_imm[7:6]}, r_imm, C_ADDI);
      push(8'h01, 3'd0, 3'd0, 8'h00, C_NONE);
      push(8'h01, r_rd, 3'd1, 8'h00, C_BRZ);
      push(r_pc, 3'd0, 3'd0, 8'h00, C_NONE);
      push_halt(r_pc, 2);
      do_reset("rand");
      drain($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/as_sequencer.md
Name: as_sequencer

Overview:
Instruction sequencer and control unit for the 8-bit embedded processor ALU/register datapath.
- Fetches 16-bit instructions from an external synchronous-read program memory.
- Decodes each instruction into ALU mux selects, ACC controls, register-file addresses and the write enable.
- Handles branches on the ALU zero flag, a hardware REPEAT loop and HALT.
- Sits between program memory and the ALU/register file; it is the only driver of their control inputs.

Parameters:
n, 8, datapath width; width of the immediate output.
PC_W, 8, program counter width; program memory depth is 2**PC_W words.

Ports:
clk  input  1  system clock, rising edge.
n_reset  input  1  asynchronous active-low reset.
instr  input  16  program memory read data; valid the cycle after pc is presented.
z  input  1  ALU zero flag, combinational from the current-cycle ALU controls.
pc  output  PC_W  program memory address.
rd_addr  output  3  register-file Rd index.
rs_addr  output  3  register-file Rs index.
immediate  output  n  ALU immediate operand.
add_a_sel  output  1  ALU adder A select (1 = SW[8] replicated).
add_b_sel  output  1  ALU adder B select (1 = immediate, 0 = Rs*imm).
acc_en  output  1  ACC write enable.
acc_add  output  1  feed ACC back into adder A.
in_en  output  1  route SW[7:0] onto the writeback bus.
reg_we  output  1  register-file write enable.
halted  output  1  high while in HALT.
illegal  output  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Instruction fields: op=instr[15:12], rd=instr[11:9], rs=instr[8:6], imm=instr[7:0]. imm overlaps rs for immediate-only ops, which is acceptable.
- States: FETCH, EXEC, HALT. On reset: state=FETCH, pc=0, rpt_cnt=0, all control outputs 0, immediate=0, halted=0.
- FETCH: presents pc; all controls 0; next state EXEC.
- EXEC: instr is latched into an internal IR on entry and held for the whole EXEC, including repeats. Controls are decoded combinationally from IR and asserted for exactly one cycle.
- Each instruction therefore takes 2 cycles (FETCH+EXEC), plus 1 per extra repeat.
- Opcode decode (controls not listed are 0):
  - 0x0 NOP: no controls asserted.
  - 0x1 ADDI: Rd <= Rd+imm. add_b_sel=1, reg_we=1, acc_en=1.
  - 0x2 MACI: Rd <= Rd+Rs*imm. add_b_sel=0, reg_we=1, acc_en=1.
  - 0x3 IN: Rd <= SW[7:0]. in_en=1, reg_we=1.
  - 0x4 ACCI: ACC <= ACC+imm. acc_add=1, add_b_sel=1, acc_en=1.
  - 0x5 BRZ: tests Rd with add_b_sel=1 and immediate forced to 0. If z=1 then pc <= imm[PC_W-1:0], else pc <= pc+1.
  - 0x6 BSW: add_a_sel=1, add_b_sel=1, immediate forced to 0. Branch to imm when z=1, i.e. when SW[8]=0.
  - 0x7 REPEAT: rpt_cnt <= imm; pc+1. The next instruction executes max(imm,1) times.
  - 0xF HALT: go to HALT; halted=1; pc is held. HALT is left only by reset.
  - Any other opcode: treated as NOP, and illegal pulses for 1 cycle in EXEC.
- Leaving EXEC:
  - If rpt_cnt>1 and the instruction is not a branch, REPEAT or HALT: rpt_cnt decrements and the state stays in EXEC with IR unchanged. reg_we/acc_en pulse every cycle.
  - Otherwise rpt_cnt <= 0, pc advances (or branches), and the state goes to FETCH.
- A taken or untaken branch, a REPEAT or a HALT cancels any pending repeat (rpt_cnt <= 0).
- In every branch or increment case other than HALT, pc wraps modulo 2**PC_W.
- A reset mid-EXEC or mid-repeat aborts immediately: no further reg_we, and pc returns to 0.
- immediate = imm zero-extended to n bits, except forced to 0 for BRZ/BSW.
- rd_addr/rs_addr are driven from IR in EXEC and are 0 in FETCH/HALT.

Optional Feature:
AS_SINGLE_STEP_EN:
- When defined, adds input port step (1 bit, asynchronous pushbutton).
- step passes through a 2-flop synchronizer and a rising-edge detector.
- FETCH holds (pc stable, controls 0) until a detected step edge, so exactly one instruction executes per press. A REPEAT body counts as one instruction.
- When undefined, there is no step port and FETCH always advances after 1 cycle.

Test Plan:
- Reset, then program {ADDI r1,5; HALT}:
  - pc sequence 0,0,1,1.
  - reg_we=1 only in cycle 2, with rd_addr=1, immediate=5, add_b_sel=1.
  - halted=1 from cycle 4 and stays high for 20 cycles.
- BRZ r2,0x10 with z driven 1 -> pc=0x10 at the next FETCH. Same with z=0 -> pc=1. immediate=0 during the BRZ EXEC in both cases.
- REPEAT 3; MACI r1,r2,2 -> reg_we high for exactly 3 consecutive cycles with IR stable, then pc=2. REPEAT 0 -> exactly 1 execution.
- pc=0xFF executing NOP -> next pc=0x00 (wrap). Opcode 0x9 -> illegal pulses once, with no reg_we/acc_en.
- Assert n_reset during the second cycle of a REPEAT 5 body -> all outputs 0 asynchronously, pc=0, and no reg_we after reset release until the program re-executes.
- With AS_SINGLE_STEP_EN: no step -> pc frozen for 50 cycles; each step pulse advances exactly one instruction; a pulse shorter than a clock period but spanning an edge registers once.
